// File: rtl/spi_mult_pkg.sv
// Shared types and frame-length helpers for the SPI multiplier peripheral.
package spi_mult_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_CALC,
        ST_TX,
        ST_HOLD
    } state_t;

    function automatic int rx_bits(input int w);
        return 2 * w;
    endfunction

    function automatic int gap_bits(input int w);
        return w;
    endfunction

    function automatic int tx_bits(input int w);
        return 2 * w;
    endfunction

    function automatic int cnt_width(input int w);
        return $clog2(5 * w + 1);
    endfunction

endpackage

// File: rtl/seq_mult.sv
// Shift-add multiplier: one load cycle plus WIDTH add/shift cycles.
// Signed operands are multiplied as magnitudes and the result negated at the end.
module seq_mult
    import spi_mult_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SIGNED = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_prod,
    output logic                 o_done
);
    localparam int PW   = 2 * WIDTH;
    localparam int CNTW = $clog2(WIDTH + 1);

    logic [PW-1:0]    r_mc;
    logic [PW-1:0]    r_acc;
    logic [WIDTH-1:0] r_mp;
    logic [CNTW-1:0]  r_cnt;
    logic             r_neg;
    logic             r_busy;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_sum;

    always_comb begin
        w_a_neg = (SIGNED != 0) && i_a[WIDTH-1];
        w_b_neg = (SIGNED != 0) && i_b[WIDTH-1];
        // Magnitude of the most negative value still fits as an unsigned WIDTH-bit number
        w_a_mag = w_a_neg ? (~i_a + WIDTH'(1)) : i_a;
        w_b_mag = w_b_neg ? (~i_b + WIDTH'(1)) : i_b;
        w_sum   = r_acc + (r_mp[0] ? r_mc : '0);
        o_prod  = r_neg ? (~w_sum + PW'(1)) : w_sum;
        o_done  = r_busy && (r_cnt == CNTW'(1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mc   <= '0;
            r_acc  <= '0;
            r_mp   <= '0;
            r_cnt  <= '0;
            r_neg  <= 1'b0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_mc   <= PW'(w_a_mag);
            r_mp   <= w_b_mag;
            r_acc  <= '0;
            r_neg  <= w_a_neg ^ w_b_neg;
            r_cnt  <= CNTW'(WIDTH);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc <= w_sum;
            r_mc  <= {r_mc[PW-2:0], 1'b0};
            r_mp  <= r_mp >> 1;
            r_cnt <= r_cnt - CNTW'(1);
            if (r_cnt == CNTW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_mult_periph.sv
// SPI-slave multiplier: receives A and B on MOSI, waits WIDTH SCLK periods,
// returns the 2*WIDTH-bit product on MISO. All SPI pins are oversampled in i_clk.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   IDLE    | waiting for CS high (only after CS seen low since reset)
//   RX      | shifting 2*WIDTH operand bits in on rising SCLK
//   CALC    | multiplier running, counting WIDTH gap edges
//   TX      | product out on falling SCLK, 2*WIDTH rising edges
//   HOLD    | frame complete, ignore SCLK until CS low
module spi_mult_periph
    import spi_mult_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SIGNED      = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sclk,
    input  logic i_cs,
    input  logic i_mosi,
    output logic o_miso,
    output logic o_busy,
    output logic o_done
);
    localparam int PW       = 2 * WIDTH;
    localparam int RX_BITS  = rx_bits(WIDTH);
    localparam int GAP_BITS = gap_bits(WIDTH);
    localparam int TX_BITS  = tx_bits(WIDTH);
    localparam int CW       = cnt_width(WIDTH);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_sclk_d;
    logic                   r_armed;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [PW-1:0]  r_rx;
    logic [PW-1:0]  r_tx;
    logic [PW-1:0]  r_prod;
    logic           r_start;
    logic           r_miso;
    logic           r_busy;
    logic           r_done;

    logic           w_sclk_s;
    logic           w_cs_s;
    logic           w_mosi_s;
    logic           w_rise;
    logic           w_fall;
    logic [PW-1:0]  w_prod;
    logic           w_mult_done;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise   = w_sclk_s & ~r_sclk_d;
    assign w_fall   = ~w_sclk_s & r_sclk_d;

    assign o_miso = r_miso;
    assign o_busy = r_busy;
    assign o_done = r_done;

    // r_fill marks when the synchroniser holds real pin values again after reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_fill      <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_sclk_d    <= w_sclk_s;
        end
    end

    seq_mult #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_mult (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (r_start),
        .i_a     (r_rx[PW-1 -: WIDTH]),
        .i_b     (r_rx[WIDTH-1:0]),
        .o_prod  (w_prod),
        .o_done  (w_mult_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prod <= '0;
        end else if (w_mult_done) begin
            r_prod <= w_prod;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rx    <= '0;
            r_tx    <= '0;
            r_start <= 1'b0;
            r_miso  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            if (r_fill[SYNC_STAGES-1] && !w_cs_s) begin
                r_armed <= 1'b1;
            end

            if (r_state != ST_IDLE && !w_cs_s) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_rx    <= '0;
                r_tx    <= '0;
                r_miso  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cs_s && r_armed) begin
                            r_state <= ST_RX;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_RX: begin
                        if (w_rise) begin
                            r_rx <= {r_rx[PW-2:0], w_mosi_s};
                            if (r_cnt == CW'(RX_BITS - 1)) begin
                                r_state <= ST_CALC;
                                r_cnt   <= '0;
                                r_start <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                    ST_CALC: begin
                        if (w_rise) begin
                            if (r_cnt == CW'(GAP_BITS - 1)) begin
                                r_state <= ST_TX;
                                r_cnt   <= '0;
                                r_tx    <= r_prod;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                    ST_TX: begin
                        if (w_fall) begin
                            r_miso <= r_tx[PW-1];
                            r_tx   <= {r_tx[PW-2:0], 1'b0};
                        end
                        if (w_rise) begin
                            if (r_cnt == CW'(TX_BITS - 1)) begin
                                r_state <= ST_HOLD;
                                r_cnt   <= '0;
                                r_miso  <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                    ST_HOLD: begin
                        r_miso <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_mult_periph.sv
// Directed bench for spi_mult_periph: three instances (4-bit unsigned,
// 4-bit signed, 8-bit unsigned with 3 sync stages) driven by a bit-banged SPI host.
module tb_spi_mult_periph;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sclk = '0;
    logic [2:0] cs   = '0;
    logic [2:0] mosi = '0;
    logic [2:0] miso;
    logic [2:0] busy;
    logic [2:0] done;

    int errors = 0;
    int checks = 0;
    int done_cnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    spi_mult_periph #(.WIDTH(4), .SIGNED(0), .SYNC_STAGES(2)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_sclk(sclk[0]), .i_cs(cs[0]), .i_mosi(mosi[0]),
        .o_miso(miso[0]), .o_busy(busy[0]), .o_done(done[0]));
    spi_mult_periph #(.WIDTH(4), .SIGNED(1), .SYNC_STAGES(2)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_sclk(sclk[1]), .i_cs(cs[1]), .i_mosi(mosi[1]),
        .o_miso(miso[1]), .o_busy(busy[1]), .o_done(done[1]));
    spi_mult_periph #(.WIDTH(8), .SIGNED(0), .SYNC_STAGES(3)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_sclk(sclk[2]), .i_cs(cs[2]), .i_mosi(mosi[2]),
        .o_miso(miso[2]), .o_busy(busy[2]), .o_done(done[2]));

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (done[d]) done_cnt[d] <= done_cnt[d] + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic half();
        repeat (10) @(negedge clk);
    endtask

    // One host frame: n_edges SCLK pulses with CS high, then extra pulses, then CS low unless keep_cs.
    task automatic frame(input int d, input int w, input logic [31:0] ops, input int n_edges,
                         input int extra, input bit keep_cs,
                         output logic [31:0] got, output bit busy_all, output bit busy_any,
                         output bit x_miso, output int ndone);
        int d0;
        d0       = done_cnt[d];
        got      = '0;
        busy_all = 1'b1;
        busy_any = 1'b0;
        x_miso   = 1'b0;
        cs[d]    = 1'b1;
        half();
        for (int i = 0; i < n_edges; i++) begin
            mosi[d] = (i < 2 * w) ? ops[2 * w - 1 - i] : 1'b0;
            half();
            if (i >= 3 * w) got = {got[30:0], miso[d]};
            if (!busy[d]) busy_all = 1'b0;
            if (busy[d])  busy_any = 1'b1;
            sclk[d] = 1'b1;
            half();
            sclk[d] = 1'b0;
        end
        for (int i = 0; i < extra; i++) begin
            half();
            x_miso |= miso[d];
            sclk[d] = 1'b1;
            half();
            x_miso |= miso[d];
            sclk[d] = 1'b0;
        end
        half();
        if (!keep_cs) begin
            cs[d] = 1'b0;
            half();
        end
        ndone = done_cnt[d] - d0;
    endtask

    typedef struct {
        int          d;
        int          w;
        logic [31:0] ops;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] got;
    bit          b_all, b_any, xm;
    int          nd;

    initial begin
        vecs[0] = '{0, 4, 32'h16,   32'h06};
        vecs[1] = '{0, 4, 32'hFF,   32'hE1};
        vecs[2] = '{0, 4, 32'h23,   32'h06};
        vecs[3] = '{0, 4, 32'h09,   32'h00};
        vecs[4] = '{1, 4, 32'hD5,   32'hF1};
        vecs[5] = '{1, 4, 32'h88,   32'h40};
        vecs[6] = '{1, 4, 32'h78,   32'hC8};
        vecs[7] = '{2, 8, 32'hFF02, 32'h01FE};
        vecs[8] = '{2, 8, 32'hFFFF, 32'hFE01};

        repeat (5) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset miso%0d", d), 32'(miso[d]), 32'd0);
            check($sformatf("reset busy%0d", d), 32'(busy[d]), 32'd0);
            check($sformatf("reset done%0d", d), 32'(done[d]), 32'd0);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            frame(vecs[k].d, vecs[k].w, vecs[k].ops, 5 * vecs[k].w, 0, 1'b0, got, b_all, b_any, xm, nd);
            check($sformatf("vec%0d product", k), got, vecs[k].exp);
            check($sformatf("vec%0d done pulses", k), nd, 1);
            check($sformatf("vec%0d busy in frame", k), 32'(b_all), 32'd1);
            check($sformatf("vec%0d busy after", k), 32'(busy[vecs[k].d]), 32'd0);
            check($sformatf("vec%0d miso idle", k), 32'(miso[vecs[k].d]), 32'd0);
        end

        // Abort after 5 RX bits, then a complete frame
        frame(0, 4, 32'h16, 5, 0, 1'b0, got, b_all, b_any, xm, nd);
        check("abort done pulses", nd, 0);
        check("abort miso", got, 32'd0);
        check("abort busy after", 32'(busy[0]), 32'd0);
        frame(0, 4, 32'h23, 20, 0, 1'b0, got, b_all, b_any, xm, nd);
        check("post-abort product", got, 32'h06);
        check("post-abort done pulses", nd, 1);

        // Extra SCLK edges after the last product bit with CS still high
        frame(0, 4, 32'hFF, 20, 3, 1'b0, got, b_all, b_any, xm, nd);
        check("extra-edge product", got, 32'hE1);
        check("extra-edge miso", 32'(xm), 32'd0);
        check("extra-edge done pulses", nd, 1);

        // Reset in TX while CS held high; third product bit (1) is on MISO
        frame(0, 4, 32'hFF, 14, 0, 1'b1, got, b_all, b_any, xm, nd);
        check("pre-reset miso", 32'(miso[0]), 32'd1);
        check("pre-reset busy", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset-in-tx miso", 32'(miso[0]), 32'd0);
        check("reset-in-tx busy", 32'(busy[0]), 32'd0);
        frame(0, 4, 32'h16, 20, 0, 1'b1, got, b_all, b_any, xm, nd);
        check("cs-held no frame done", nd, 0);
        check("cs-held no busy", 32'(b_any), 32'd0);
        check("cs-held miso", got, 32'd0);
        cs[0] = 1'b0;
        half();
        frame(0, 4, 32'h16, 20, 0, 1'b0, got, b_all, b_any, xm, nd);
        check("after cs cycle product", got, 32'h06);
        check("after cs cycle done", nd, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_mult_periph.md
# spi_mult_periph

Parametrised SPI-slave multiplier peripheral, the next generation of the 4-bit SPI multiplier. A host shifts two WIDTH-bit operands in on MOSI, waits WIDTH SCLK periods, then shifts the 2·WIDTH-bit product out on MISO MSB-first. It adds a generic operand width, a signed mode, an oversampled SCLK/CS synchroniser in the CLK domain, frame abort and status outputs. It sits in the peripheral tile between the SPI pins and the system clock domain.

## Interface
- WIDTH, 4: operand width in bits; product is 2·WIDTH bits; legal 2..16.
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands and product.
- SYNC_STAGES, 2: flop stages on SCLK, CS and MOSI before use; legal 2..3.
- CLK  input  1  system clock; all state changes on rising CLK.
- RST  input  1  synchronous, active-high reset.
- SCLK  input  1  SPI clock, asynchronous to CLK, idle low.
- CS  input  1  chip select, active high, asynchronous.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first; 0 when not transmitting.
- BUSY  output  1  high while a frame is in progress (RX, CALC, TX).
- DONE  output  1  one-CLK pulse when the last product bit has been sampled.

## Operation
- Synchronised SCLK/CS/MOSI; rising/falling SCLK edges detected on the synchronised copy (one extra flop for edge compare).
- Frame = 5·WIDTH SCLK rising edges while CS high: 2·WIDTH RX, WIDTH CALC, 2·WIDTH TX.
- FSM states IDLE, RX, CALC, TX, HOLD.
  - IDLE: CS synchronised high → RX, edge counter cleared.
  - RX: each rising edge shifts MOSI into a 2·WIDTH register (A = first WIDTH bits, B = next WIDTH, both MSB first). After edge 2·WIDTH → CALC, multiplier started.
  - CALC: multiplier runs (WIDTH+1 CLK cycles); MISO 0; rising edges counted; after WIDTH edges → TX, product loaded into shift register.
  - TX: on each falling edge MISO presents the next product bit, MSB first, starting with the falling edge right after the last CALC rising edge; host samples on rising edge. After 2·WIDTH rising edges DONE pulses and → HOLD.
  - HOLD: MISO 0, further edges ignored until CS low → IDLE.
- CS low in any non-IDLE state: abort → IDLE next CLK, MISO 0, no DONE, shift registers cleared.
- Arithmetic: unsigned A·B, zero-extended to 2·WIDTH; signed mode full 2·WIDTH two's-complement product (e.g. −8·−8 = +64 fits for WIDTH=4). No truncation or saturation.
- RST mid-frame: identical to abort; CS still high after reset does NOT start a frame until CS seen low then high.

## Timing
- Reset values: MISO 0, BUSY 0, DONE 0, FSM IDLE, all registers 0.
- Input latency: pin edge acts SYNC_STAGES+1 CLK cycles later.
- MISO changes SYNC_STAGES+1 CLK cycles after SCLK pin falling edge.
- Requirement: each SCLK half-period ≥ SYNC_STAGES+3 CLK cycles; CALC gap (WIDTH half-periods min) covers multiplier latency WIDTH+1.
- BUSY rises the CLK after CS detected high; falls with DONE or abort.
- DONE: single CLK cycle, coincident with the TX→HOLD transition.

## Structure
- Package spi_mult_pkg: FSM state enum, frame-length helpers (RX_BITS=2·WIDTH, GAP_BITS=WIDTH, TX_BITS=2·WIDTH), counter width = clog2(5·WIDTH+1).
- Sub-module seq_mult: start/done shift-add multiplier, WIDTH+1 cycles, signed handled by magnitude multiply plus conditional negate.
- Top holds synchroniser, edge detect, FSM, counters, RX/TX shift registers.

## Test plan
- WIDTH=4 unsigned, A=0001, B=0110, 10 CLK per SCLK half-period -> after 4 gap edges MISO bits 0,0,0,0,0,1,1,0 (0x06); DONE one pulse.
- WIDTH=4 unsigned, A=1111, B=1111 -> MISO 11100001 (225); SIGNED=1, A=1101 (−3), B=0101 (5) -> 11110001 (−15).
- WIDTH=8 unsigned, A=0xFF, B=0x02 -> 16-bit MISO 0x01FE; BUSY high from CS rise through last bit.
- CS dropped after 5 RX bits, then full new frame 0010×0011 -> first frame no DONE, MISO 0; second frame returns 0x06.
- RST asserted during TX with CS held high -> MISO 0, BUSY 0 next CLK; no frame until CS cycles low/high.
- Extra SCLK edges after final bit with CS high -> MISO stays 0, no second DONE.
